// File: rtl/fp_stream_pkg.sv
// Shared defaults and sizing helpers for the FP stream issuer and its result FIFO.
package fp_stream_pkg;

    localparam int unsigned DefaultWidth   = 32;
    localparam int unsigned DefaultLatency = 12;
    localparam int unsigned DefaultDepth   = 16;

    // Counters must be able to hold the value DEPTH itself, hence the extra bit.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; a push into an empty FIFO is visible on rdata the same cycle.
module sync_fifo_fwft
    import fp_stream_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth,
    localparam int unsigned CntW = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic [CntW-1:0]  count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             bypass, do_write, do_read;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CntW'(DEPTH));
    assign count  = count_q;
    assign rvalid = !empty || push;

    // An empty FIFO popped in the same cycle it is pushed hands the word straight through.
    assign bypass   = push && empty && pop;
    assign do_write = push && !full && !bypass;
    assign do_read  = pop && !empty;

    always_comb begin
        rdata = '0;
        if (!empty) begin
            rdata = mem[rd_ptr_q];
        end else if (push) begin
            rdata = wdata;
        end
    end

    always_comb begin
        count_d = count_q;
        if (do_write && !do_read) begin
            count_d = count_q + CntW'(1);
        end else if (!do_write && do_read) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_write) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_read) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/fp_stream_issuer.sv
// Credit-based issuer feeding a fixed-latency FP core and buffering its results in order.
// Optional protocol checker enabled by defining FP_STREAM_ISSUER_CHECK_EN.
module fp_stream_issuer
    import fp_stream_pkg::*;
#(
    parameter int unsigned WIDTH   = DefaultWidth,
    parameter int unsigned LATENCY = DefaultLatency,
    parameter int unsigned DEPTH   = DefaultDepth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             m_axis_a_tvalid,
    output logic [WIDTH-1:0] m_axis_a_tdata,
    output logic             m_axis_b_tvalid,
    output logic [WIDTH-1:0] m_axis_b_tdata,
    input  logic             s_axis_result_tvalid,
    input  logic [WIDTH-1:0] s_axis_result_tdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             err
);

    localparam int unsigned CntW = cnt_width(DEPTH);

    logic             issue_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CntW-1:0]  inflight_q, inflight_d;
    logic [CntW-1:0]  fifo_count;
    logic             fifo_full, fifo_empty;
    logic [CntW:0]    used;
    logic             accept, result_ok, pop;

    // The pair sitting in the issue register is not yet inflight but still owns a FIFO slot.
    assign used = {1'b0, fifo_count} + {1'b0, inflight_q} + {{CntW{1'b0}}, issue_q};
    assign in_ready = !fifo_full && (used < (CntW + 1)'(DEPTH));
    assign accept   = in_valid && in_ready;

    assign m_axis_a_tvalid = issue_q;
    assign m_axis_b_tvalid = issue_q;
    assign m_axis_a_tdata  = a_q;
    assign m_axis_b_tdata  = b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            issue_q <= accept;
            if (accept) begin
                a_q <= in_a;
                b_q <= in_b;
            end
        end
    end

    // Results with nothing outstanding are stale (e.g. from before a reset) and are dropped.
    assign result_ok = s_axis_result_tvalid && (inflight_q != '0);

    always_comb begin
        inflight_d = inflight_q;
        unique case ({issue_q, result_ok})
            2'b10:   inflight_d = inflight_q + CntW'(1);
            2'b01:   inflight_d = inflight_q - CntW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign pop = out_valid && out_ready;

    sync_fifo_fwft #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (result_ok),
        .wdata (s_axis_result_tdata),
        .pop   (pop),
        .rdata (out_data),
        .rvalid(out_valid),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign busy = (inflight_q != '0) || !fifo_empty;

`ifdef FP_STREAM_ISSUER_CHECK_EN
    localparam int unsigned WdLimit = LATENCY + 2;
    localparam int unsigned WdW     = $clog2(WdLimit + 1);

    logic [WdW-1:0] wd_q, wd_d;
    logic           err_q, err_d;

    // wd_q counts completed cycles with work outstanding and no result returned.
    always_comb begin
        wd_d  = wd_q;
        err_d = err_q;
        if (s_axis_result_tvalid || (inflight_q == '0)) begin
            wd_d = '0;
        end else if (wd_q != WdW'(WdLimit)) begin
            wd_d = wd_q + WdW'(1);
        end
        if (s_axis_result_tvalid && (inflight_q == '0)) begin
            err_d = 1'b1;
        end
        if (!s_axis_result_tvalid && (inflight_q != '0) && (wd_q >= WdW'(WdLimit - 1))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
